// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA engine sharing arbiter.
//   - default word width and WAIT timeout length
//   - FSM state encoding used by rsa_share_arbiter
package rsa_pkg;

  localparam int unsigned DefWordSize      = 8;
  localparam int unsigned DefTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } rsa_state_e;

endpackage

// File: rtl/rsa_share_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   req     : request vector
//   pointer : index of the last granted requester
//   index   : first requester with req high, searching upward from pointer+1
//   found   : high when any request is pending
module rr_select #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   pointer,
  output logic [IdxW-1:0]   index,
  output logic              found
);

  always_comb begin
    int unsigned cand;
    cand  = 0;
    index = '0;
    found = 1'b0;
    // k runs 1..NumReq so the last grant itself is the lowest-priority candidate.
    for (int unsigned k = 1; k <= NumReq; k++) begin
      cand = (pointer + k) % NumReq;
      if (!found && req[IdxW'(cand)]) begin
        found = 1'b1;
        index = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/rsa_share_arbiter.sv
// rsa_share_arbiter: shares one modular-exponentiation engine among NumReq
// requesters using round-robin arbitration.
//   clk, reset                  : clock, synchronous active-high reset
//   req / req_text/key/mod      : per-requester level request and packed operands
//   ack, resp_text, resp_err    : one-cycle completion pulse and its result
//   eng_text/key/mod, eng_go    : registered operands and start pulse to engine
//   eng_done, eng_result        : engine completion pulse and result
//   busy, grant_id              : activity flag and current/last granted index
module rsa_share_arbiter
  import rsa_pkg::*;
#(
  parameter int unsigned WordSize      = DefWordSize,
  parameter int unsigned NumReq        = 4,
  parameter int unsigned TimeoutCycles = DefTimeoutCycles,
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NumReq-1:0]          req,
  input  logic [NumReq*WordSize-1:0] req_text,
  input  logic [NumReq*WordSize-1:0] req_key,
  input  logic [NumReq*WordSize-1:0] req_mod,
  output logic [NumReq-1:0]          ack,
  output logic [WordSize-1:0]        resp_text,
  output logic                       resp_err,
  output logic [WordSize-1:0]        eng_text,
  output logic [WordSize-1:0]        eng_key,
  output logic [WordSize-1:0]        eng_mod,
  output logic                       eng_go,
  input  logic                       eng_done,
  input  logic [WordSize-1:0]        eng_result,
  output logic                       busy,
  output logic [IdxW-1:0]            grant_id
);

  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  rsa_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr, rr_ptr_d;
  logic [IdxW-1:0]     grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WordSize-1:0] eng_text_d, eng_key_d, eng_mod_d;
  logic [WordSize-1:0] resp_text_d;
  logic                resp_err_d;

  logic [IdxW-1:0]     sel_idx;
  logic                sel_found;
  logic [WordSize-1:0] sel_text, sel_key, sel_mod;

  rr_select #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_rr_select (
    .req     (req),
    .pointer (rr_ptr),
    .index   (sel_idx),
    .found   (sel_found)
  );

  assign sel_text = req_text[sel_idx*WordSize +: WordSize];
  assign sel_key  = req_key [sel_idx*WordSize +: WordSize];
  assign sel_mod  = req_mod [sel_idx*WordSize +: WordSize];

  assign eng_go = (state_q == ST_ISSUE);
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    ack = '0;
    if (state_q == ST_RESP) ack[grant_id] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr;
    grant_d     = grant_id;
    cnt_d       = cnt_q;
    eng_text_d  = eng_text;
    eng_key_d   = eng_key;
    eng_mod_d   = eng_mod;
    resp_text_d = resp_text;
    resp_err_d  = resp_err;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          grant_d    = sel_idx;
          eng_text_d = sel_text;
          eng_key_d  = sel_key;
          eng_mod_d  = sel_mod;
          // Modulus 0 or 1 is meaningless: answer with an error, skip the engine.
          if (sel_mod[WordSize-1:1] == '0) begin
            state_d     = ST_RESP;
            resp_text_d = '0;
            resp_err_d  = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // Done is tested first so it beats the timeout on the terminal cycle.
        if (eng_done) begin
          state_d     = ST_RESP;
          resp_text_d = eng_result;
          resp_err_d  = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d     = ST_RESP;
          resp_text_d = '0;
          resp_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        rr_ptr_d = grant_id;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_ptr    <= IdxW'(NumReq - 1);
      grant_id  <= '0;
      cnt_q     <= '0;
      eng_text  <= '0;
      eng_key   <= '0;
      eng_mod   <= '0;
      resp_text <= '0;
      resp_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant_id  <= grant_d;
      cnt_q     <= cnt_d;
      eng_text  <= eng_text_d;
      eng_key   <= eng_key_d;
      eng_mod   <= eng_mod_d;
      resp_text <= resp_text_d;
      resp_err  <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_rsa_share_arbiter.sv
// Directed self-checking bench for rsa_share_arbiter with a behavioural engine.
module tb_rsa_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_text = '0, req_key = '0, req_mod = '0;
  logic [3:0]  ack;
  logic [7:0]  resp_text;
  logic        resp_err;
  logic [7:0]  eng_text, eng_key, eng_mod;
  logic        eng_go;
  logic        eng_done;
  logic [7:0]  eng_result;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural engine: pulses done mdl_delay cycles after eng_go.
  logic       eng_en = 1'b0;
  int         mdl_delay = 10;
  int         mdl_cnt = 0;
  logic       mdl_done = 1'b0;
  logic [7:0] mdl_val = '0;
  logic       man_done = 1'b0;
  logic [7:0] man_result = '0;

  assign eng_done   = mdl_done | man_done;
  assign eng_result = man_done ? man_result : mdl_val;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #3;
    mdl_done = 1'b0;
    if (reset) begin
      mdl_cnt = 0;
    end else begin
      if (mdl_cnt > 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) mdl_done = 1'b1;
      end
      if (eng_go && eng_en) mdl_cnt = mdl_delay;
    end
  end

  rsa_share_arbiter #(
    .WordSize      (8),
    .NumReq        (4),
    .TimeoutCycles (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_text   (req_text),
    .req_key    (req_key),
    .req_mod    (req_mod),
    .ack        (ack),
    .resp_text  (resp_text),
    .resp_err   (resp_err),
    .eng_text   (eng_text),
    .eng_key    (eng_key),
    .eng_mod    (eng_mod),
    .eng_go     (eng_go),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic set_slot(input int i, input logic [7:0] t, input logic [7:0] k, input logic [7:0] m);
    req_text[8*i +: 8] = t;
    req_key [8*i +: 8] = k;
    req_mod [8*i +: 8] = m;
  endtask

  // Steps negedges until an ack is seen; ack_c stays -1 if the bound expires.
  task automatic run_op(input int max_cyc, output int go_c, output int ack_c,
                        output logic [3:0] ack_v, output logic [7:0] txt, output logic err);
    go_c = -1; ack_c = -1; ack_v = '0; txt = '0; err = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (eng_go && go_c < 0) go_c = cyc;
      if (ack != '0) begin
        ack_c = cyc; ack_v = ack; txt = resp_text; err = resp_err;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (eng_go !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", eng_go); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    checks++; if ({eng_text, eng_key, eng_mod} !== 24'h0) begin errors++;
      $display("FAIL reset_eng_ops got %h want 000000", {eng_text, eng_key, eng_mod}); end
    checks++; if ({resp_text, resp_err} !== 9'h0) begin errors++;
      $display("FAIL reset_resp got %h want 000", {resp_text, resp_err}); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int g, go_c, done_c, ack_c;
    eng_en = 1'b1; mdl_delay = 10; mdl_val = 8'h06;
    @(negedge clk);
    set_slot(0, 8'd5, 8'd3, 8'd7);
    req = 4'b0001;
    g = cyc; go_c = -1; done_c = -1; ack_c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (eng_go && go_c < 0) begin
        go_c = cyc;
        checks++; if ({eng_text, eng_key, eng_mod} !== {8'd5, 8'd3, 8'd7}) begin errors++;
          $display("FAIL basic_ops got %h want 050307", {eng_text, eng_key, eng_mod}); end
        // Requester withdraws and scribbles its operands after the grant.
        req = 4'b0000;
        set_slot(0, 8'hFF, 8'hEE, 8'h00);
      end
      if (eng_done && done_c < 0) done_c = cyc;
      if (ack != '0) begin
        ack_c = cyc;
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL basic_ack got %b want 0001", ack); end
        checks++; if (resp_text !== 8'd6) begin errors++; $display("FAIL basic_text got %0d want 6", resp_text); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", resp_err); end
        checks++; if (eng_text !== 8'd5 || eng_mod !== 8'd7) begin errors++;
          $display("FAIL basic_hold got text=%0d mod=%0d want 5 7", eng_text, eng_mod); end
        break;
      end
    end
    checks++; if (go_c !== g + 1) begin errors++; $display("FAIL basic_go_lat got %0d want %0d", go_c, g + 1); end
    checks++; if (done_c < 0 || ack_c !== done_c + 1) begin errors++;
      $display("FAIL basic_ack_lat got %0d want %0d", ack_c, done_c + 1); end
  endtask

  task automatic test_bad_mod();
    int g, go_c, ack_c; logic [3:0] av; logic [7:0] t; logic e;
    @(negedge clk);
    set_slot(1, 8'd9, 8'd4, 8'd1);
    req = 4'b0010;
    g = cyc;
    run_op(10, go_c, ack_c, av, t, e);
    req = 4'b0000;
    checks++; if (go_c !== -1) begin errors++; $display("FAIL badmod_go got %0d want -1 (none)", go_c); end
    checks++; if (ack_c !== g + 1) begin errors++; $display("FAIL badmod_lat got %0d want %0d", ack_c, g + 1); end
    checks++; if (av !== 4'b0010) begin errors++; $display("FAIL badmod_ack got %b want 0010", av); end
    checks++; if (e !== 1'b1 || t !== 8'h00) begin errors++;
      $display("FAIL badmod_resp got err=%b text=%h want 1 00", e, t); end
    checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL badmod_grant got %0d want 1", grant_id); end
  endtask

  task automatic test_round_robin();
    int go_c, ack_c; logic [3:0] av; logic [7:0] t; logic e;
    int exp_a[4] = '{0, 1, 2, 3};
    int exp_b[4] = '{0, 2, 0, 2};
    logic [3:0] want;
    do_reset();
    eng_en = 1'b1; mdl_delay = 3; mdl_val = 8'h11;
    for (int i = 0; i < 4; i++) set_slot(i, 8'd2, 8'd2, 8'd7);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      run_op(30, go_c, ack_c, av, t, e);
      want = 4'b0001 << exp_a[k];
      checks++; if (av !== want) begin errors++; $display("FAIL rr_all[%0d] got %b want %b", k, av, want); end
      req = req & ~av;
    end
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      run_op(30, go_c, ack_c, av, t, e);
      want = 4'b0001 << exp_b[k];
      checks++; if (av !== want) begin errors++; $display("FAIL rr_held[%0d] got %b want %b", k, av, want); end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    int go_c, ack_c; logic [3:0] av; logic [7:0] t; logic e;
    logic seen;
    eng_en = 1'b0;
    @(negedge clk);
    set_slot(2, 8'd3, 8'd5, 8'd11);
    req = 4'b0100;
    run_op(40, go_c, ack_c, av, t, e);
    req = 4'b0000;
    checks++; if (ack_c < 0 || go_c < 0 || ack_c - go_c !== 17) begin errors++;
      $display("FAIL timeout_lat got go=%0d ack=%0d want ack-go=17", go_c, ack_c); end
    checks++; if (av !== 4'b0100 || e !== 1'b1 || t !== 8'h00) begin errors++;
      $display("FAIL timeout_resp got ack=%b err=%b text=%h want 0100 1 00", av, e, t); end
    @(negedge clk);
    man_result = 8'h55; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ack != '0 || busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_done_ignored got activity=%b want 0", seen); end
  endtask

  task automatic test_done_on_terminal();
    int go_c, ack_c; logic [3:0] av; logic [7:0] t; logic e;
    eng_en = 1'b1; mdl_delay = 16; mdl_val = 8'h2A;
    @(negedge clk);
    set_slot(3, 8'd4, 8'd6, 8'd13);
    req = 4'b1000;
    run_op(40, go_c, ack_c, av, t, e);
    req = 4'b0000;
    checks++; if (ack_c < 0 || go_c < 0 || ack_c - go_c !== 17) begin errors++;
      $display("FAIL terminal_lat got go=%0d ack=%0d want ack-go=17", go_c, ack_c); end
    checks++; if (t !== 8'h2A || e !== 1'b0) begin errors++;
      $display("FAIL terminal_resp got text=%h err=%b want 2a 0", t, e); end
    checks++; if (av !== 4'b1000) begin errors++; $display("FAIL terminal_ack got %b want 1000", av); end
  endtask

  task automatic test_reset_mid();
    logic seen, got_go;
    eng_en = 1'b0;
    @(negedge clk);
    set_slot(3, 8'd8, 8'd2, 8'd9);
    req = 4'b1000;
    got_go = 1'b0;
    for (int i = 0; i < 10 && !got_go; i++) begin
      @(negedge clk);
      if (eng_go) got_go = 1'b1;
    end
    checks++; if (got_go !== 1'b1) begin errors++; $display("FAIL midreset_go got %b want 1", got_go); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_wait_busy got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({ack, busy, eng_go, grant_id} !== 8'h00) begin errors++;
      $display("FAIL midreset_ctrl got ack=%b busy=%b go=%b grant=%0d want all 0", ack, busy, eng_go, grant_id); end
    checks++; if ({eng_text, eng_key, eng_mod, resp_text, resp_err} !== 33'h0) begin errors++;
      $display("FAIL midreset_data got %h want 0", {eng_text, eng_key, eng_mod, resp_text, resp_err}); end
    reset = 1'b0;
    req = 4'b0000;
    man_result = 8'h33; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ack != '0 || busy) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_ack got activity=%b want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_mod();
    test_round_robin();
    test_timeout();
    test_done_on_terminal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rsa_share_arbiter.md
RSA_SHARE_ARBITER -- requirements
Module: rsa_share_arbiter

Interface
REQ-001 Parameter WordSize, default 8, is the width of text, key, modulus and result words.
REQ-002 Parameter NumReq, default 4, is the number of requesters sharing one modular-exponentiation engine.
REQ-003 Parameter TimeoutCycles, default 1024, is the maximum number of WAIT cycles before an operation is aborted.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NumReq  per-requester level request, held until its ack.
REQ-007 req_text, req_key, req_mod  input  NumReq*WordSize each  packed operands; slot i belongs to req[i].
REQ-008 ack  output  NumReq  one-cycle completion pulse to the granted requester.
REQ-009 resp_text  output  WordSize  result; valid only while any ack bit is high.
REQ-010 resp_err  output  1  result invalid (bad modulus or timeout); valid only with ack.
REQ-011 eng_text, eng_key, eng_mod  output  WordSize each  registered engine operands.
REQ-012 eng_go  output  1  one-cycle engine start pulse.
REQ-013 eng_done  input  1  engine completion pulse.
REQ-014 eng_result  input  WordSize  engine result; sampled only when eng_done is high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  clog2(NumReq)  index of the current or last granted requester.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; state updates only on clk.
REQ-018 IDLE with any req high: grant by round-robin, searching upward from (last grant + 1) mod NumReq; register grant_id and the granted operands into eng_text/key/mod.
REQ-019 IDLE with a grant whose req_mod < 2: no eng_go; next state RESP with resp_err=1 and resp_text=0.
REQ-020 IDLE with a grant whose req_mod >= 2: next state ISSUE; eng_go is high for exactly the one ISSUE cycle, then WAIT.
REQ-021 eng_text/key/mod hold stable from ISSUE through RESP; requester operand changes after the grant are ignored.
REQ-022 WAIT: timeout counter clears on entry and increments each cycle; eng_done captures eng_result and moves to RESP with resp_err=0.
REQ-023 If the counter reaches TimeoutCycles-1 without eng_done, move to RESP with resp_err=1 and resp_text=0.
REQ-024 eng_done in the same cycle as the timeout terminal count: done wins, resp_err=0.
REQ-025 RESP: ack[grant_id] high for one cycle, round-robin pointer updates to grant_id, then IDLE.
REQ-026 Latency: eng_go 1 cycle after the granting IDLE cycle; ack 1 cycle after the eng_done cycle; ack for a bad modulus 1 cycle after the granting IDLE cycle.
REQ-027 eng_done outside WAIT is ignored.
REQ-028 A req deasserted mid-operation does not abort; the ack still pulses.
REQ-029 A req still high in the IDLE cycle after its ack is treated as a new request under round-robin order.

Reset
REQ-030 While reset is high: state=IDLE; ack, resp_text, resp_err, eng_go, eng_text, eng_key, eng_mod, busy, grant_id, counter = 0; pointer set so req[0] has highest priority.
REQ-031 Reset mid-operation abandons the operation with no ack; the engine shares the same reset.

Structure
REQ-032 Shared package rsa_pkg holds the FSM state encoding and the WordSize and TimeoutCycles defaults.
REQ-033 The round-robin selection is one combinational sub-module, rr_select (inputs: req vector, pointer; outputs: index, found); all state stays in rsa_share_arbiter.

Verification (behavioural engine model)
REQ-034 req[0]=1, text=5, key=3, mod=7, model done 10 cycles after eng_go with result 6 -> eng_go 1 cycle after grant; ack[0] 1 cycle after eng_done; resp_text=6; resp_err=0.
REQ-035 Immediately after reset, req=4'b1111 held with ack-drop -> grant order 0,1,2,3; with req[0] and req[2] held continuously -> grants alternate 0,2,0,2.
REQ-036 req[1]=1, mod=1 -> no eng_go; ack[1] 1 cycle after grant; resp_err=1; resp_text=0.
REQ-037 TimeoutCycles=16, engine silent -> ack with resp_err=1 on the 17th cycle after eng_go; a later eng_done in IDLE is ignored.
REQ-038 eng_done on the timeout terminal cycle with result 0x2A -> resp_text=0x2A; resp_err=0.
REQ-039 reset high during WAIT -> next cycle all outputs 0, no ack; a subsequent eng_done is ignored.
